// File: rtl/axis_demux.sv
// Frame-aware 1:M_COUNT AXI-Stream demultiplexer.
// Select/drop are sampled on the first beat of each frame; output passes through a skid stage.
module axis_demux #(
   parameter int M_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter bit ID_ENABLE   = 0,
   parameter int ID_WIDTH    = 8,
   parameter bit DEST_ENABLE = 0,
   parameter int DEST_WIDTH  = 8,
   parameter bit USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
   input  logic                             s_axis_tvalid,
   output logic                             s_axis_tready,
   input  logic                             s_axis_tlast,
   input  logic [ID_WIDTH-1:0]              s_axis_tid,
   input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
   input  logic [USER_WIDTH-1:0]            s_axis_tuser,
   output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
   output logic [M_COUNT-1:0]               m_axis_tvalid,
   input  logic [M_COUNT-1:0]               m_axis_tready,
   output logic [M_COUNT-1:0]               m_axis_tlast,
   output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
   output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
   output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,
   input  logic                             enable,
   input  logic                             drop,
   input  logic [$clog2(M_COUNT)-1:0]       select
);

   localparam int CL = $clog2(M_COUNT);
   localparam int PW = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

   logic [CL-1:0]      select_reg, select_ctl;
   logic               drop_frame_reg, drop_ctl;
   logic               frame_reg, frame_next;
   logic               ready_reg, ready_next;
   logic               int_ready_reg, int_ready_early;
   logic               accept, out_taken;
   logic [2**CL-1:0]   sel_ok;
   logic [M_COUNT-1:0] valid_int;
   logic [M_COUNT-1:0] out_valid, out_valid_next;
   logic [M_COUNT-1:0] temp_valid, temp_valid_next;
   logic               to_out, to_temp, temp_to_out;
   logic [PW-1:0]      pay_in, out_pay, temp_pay;

   logic [DATA_WIDTH-1:0] o_data;
   logic [KEEP_WIDTH-1:0] o_keep;
   logic                  o_last;
   logic [ID_WIDTH-1:0]   o_id;
   logic [DEST_WIDTH-1:0] o_dest;
   logic [USER_WIDTH-1:0] o_user;

   for (genvar g = 0; g < 2**CL; g++) begin : g_sel
      assign sel_ok[g] = (g < M_COUNT);
   end

   // enable only gates the first beat; an open frame always runs to completion
   assign s_axis_tready = ready_reg && (enable || frame_reg);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign out_taken     = |(m_axis_tready & out_valid);
   assign pay_in        = {s_axis_tdata, s_axis_tkeep, s_axis_tlast,
                           s_axis_tid, s_axis_tdest, s_axis_tuser};

   assign int_ready_early = out_taken ||
      (!(|temp_valid) && (!(|out_valid) || !(|valid_int)));

   always_comb begin
      select_ctl = select_reg;
      drop_ctl   = drop_frame_reg;
      frame_next = frame_reg;
      valid_int  = '0;
      if (!frame_reg && accept) begin
         select_ctl = select;
         drop_ctl   = drop || !sel_ok[select];
      end
      if (accept) begin
         frame_next = !s_axis_tlast;
      end
      for (int i = 0; i < M_COUNT; i++) begin
         if (accept && !drop_ctl && select_ctl == CL'(i)) begin
            valid_int[i] = 1'b1;
         end
      end
      // a dropped frame is swallowed at full rate regardless of the outputs
      ready_next = int_ready_early || (drop_ctl && frame_next);
   end

   always_comb begin
      out_valid_next  = out_valid;
      temp_valid_next = temp_valid;
      to_out          = 1'b0;
      to_temp         = 1'b0;
      temp_to_out     = 1'b0;
      if (int_ready_reg) begin
         if (out_taken || !(|out_valid)) begin
            out_valid_next = valid_int;
            to_out         = 1'b1;
         end else begin
            temp_valid_next = valid_int;
            to_temp         = 1'b1;
         end
      end else if (out_taken) begin
         out_valid_next  = temp_valid;
         temp_valid_next = '0;
         temp_to_out     = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         select_reg     <= '0;
         drop_frame_reg <= 1'b0;
         frame_reg      <= 1'b0;
         ready_reg      <= 1'b0;
         int_ready_reg  <= 1'b0;
         out_valid      <= '0;
         temp_valid     <= '0;
      end else begin
         select_reg     <= select_ctl;
         drop_frame_reg <= drop_ctl;
         frame_reg      <= frame_next;
         ready_reg      <= ready_next;
         int_ready_reg  <= int_ready_early;
         out_valid      <= out_valid_next;
         temp_valid     <= temp_valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (to_out) begin
         out_pay <= pay_in;
      end else if (temp_to_out) begin
         out_pay <= temp_pay;
      end
      if (to_temp) begin
         temp_pay <= pay_in;
      end
   end

   assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = out_pay;

   assign m_axis_tvalid = out_valid;
   assign m_axis_tdata  = {M_COUNT{o_data}};
   assign m_axis_tkeep  = KEEP_ENABLE ? {M_COUNT{o_keep}} : '1;
   assign m_axis_tlast  = {M_COUNT{o_last}};
   assign m_axis_tid    = ID_ENABLE ? {M_COUNT{o_id}} : '0;
   assign m_axis_tdest  = DEST_ENABLE ? {M_COUNT{o_dest}} : '0;
   assign m_axis_tuser  = USER_ENABLE ? {M_COUNT{o_user}} : '0;

endmodule

// File: tb/tb_axis_demux.sv
// Scoreboard bench for axis_demux: driver queues expected beats, a forked monitor checks outputs.
module tb_axis_demux;

   logic        clk;
   logic        rst;
   logic [7:0]  s_axis_tdata;
   logic [0:0]  s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        s_axis_tlast;
   logic [7:0]  s_axis_tid;
   logic [7:0]  s_axis_tdest;
   logic [0:0]  s_axis_tuser;
   logic [31:0] m_axis_tdata;
   logic [3:0]  m_axis_tkeep;
   logic [3:0]  m_axis_tvalid;
   logic [3:0]  m_axis_tready;
   logic [3:0]  m_axis_tlast;
   logic [31:0] m_axis_tid;
   logic [31:0] m_axis_tdest;
   logic [3:0]  m_axis_tuser;
   logic        enable;
   logic        drop;
   logic [1:0]  select;

   typedef struct {
      int         port;
      logic [7:0] data;
      logic       last;
      logic [7:0] id;
      logic [7:0] dest;
      logic       user;
   } exp_t;

   exp_t sb[$];
   int   cmp = 0;
   int   bad = 0;
   bit   t5done;

   axis_demux #(
      .M_COUNT(4), .DATA_WIDTH(8), .ID_ENABLE(1), .DEST_ENABLE(1)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
      .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
      .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser),
      .enable(enable), .drop(drop), .select(select)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      cmp++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   task automatic monitor();
      exp_t e;
      logic [3:0] hs;
      int p;
      forever begin
         @(negedge clk);
         hs = m_axis_tvalid & m_axis_tready;
         if (hs != 4'b0) begin
            p = 0;
            for (int i = 0; i < 4; i++) if (hs[i]) p = i;
            cmp++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL out_beat: got port%0d data %h, want no beat",
                        p, m_axis_tdata[p*8 +: 8]);
            end else begin
               e = sb.pop_front();
               if (p != e.port || $countones(m_axis_tvalid) != 1 ||
                   m_axis_tdata[p*8 +: 8] !== e.data ||
                   m_axis_tlast[p] !== e.last ||
                   m_axis_tid[p*8 +: 8] !== e.id ||
                   m_axis_tdest[p*8 +: 8] !== e.dest ||
                   m_axis_tuser[p] !== e.user || m_axis_tkeep[p] !== 1'b1) begin
                  bad++;
                  $display("FAIL out_beat: got v=%b p%0d d=%h l=%b id=%h de=%h u=%b k=%b, want p%0d d=%h l=%b id=%h de=%h u=%b k=1",
                           m_axis_tvalid, p, m_axis_tdata[p*8 +: 8], m_axis_tlast[p],
                           m_axis_tid[p*8 +: 8], m_axis_tdest[p*8 +: 8],
                           m_axis_tuser[p], m_axis_tkeep[p],
                           e.port, e.data, e.last, e.id, e.dest, e.user);
               end
            end
         end
      end
   endtask

   // called just after a posedge; returns just after the accepting posedge
   task automatic beat(input logic [7:0] d, input logic l, input int port, output int waits);
      exp_t e;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      s_axis_tuser  = d[0];
      s_axis_tvalid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!s_axis_tready && waits <= 200) begin
         waits++;
         @(negedge clk);
      end
      if (waits > 200) begin
         cmp++;
         bad++;
         $display("FAIL accept_timeout: got no s_axis_tready for %h, want accept", d);
      end else if (port >= 0) begin
         e = '{port, d, l, s_axis_tid, s_axis_tdest, d[0]};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int w;
      int wsum;
      logic sr;
      rst = 1'b1;
      s_axis_tdata = '0;
      s_axis_tkeep = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast = 1'b0;
      s_axis_tid = 8'h01;
      s_axis_tdest = 8'h02;
      s_axis_tuser = '0;
      m_axis_tready = 4'hF;
      enable = 1'b1;
      drop = 1'b0;
      select = 2'd0;
      t5done = 1'b0;
      fork
         monitor();
      join_none

      // reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_tvalid", m_axis_tvalid, 4'b0);
      chk("rst_tready", s_axis_tready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // single frame to port 1, latency one cycle
      select = 2'd1;
      beat(8'h01, 1'b0, 1, w);
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      chk("lat_tvalid", m_axis_tvalid, 4'b0010);
      chk("lat_tdata", m_axis_tdata[15:8], 8'h01);
      @(posedge clk);
      #1;
      beat(8'h02, 1'b0, 1, w);
      beat(8'h03, 1'b0, 1, w);
      beat(8'h04, 1'b1, 1, w);
      idle(2);

      // select change mid-frame is ignored; next frame back-to-back on port 2
      wsum = 0;
      select = 2'd1;
      beat(8'h21, 1'b0, 1, w); wsum += w;
      beat(8'h22, 1'b0, 1, w); wsum += w;
      select = 2'd2;
      beat(8'h23, 1'b0, 1, w); wsum += w;
      beat(8'h24, 1'b1, 1, w); wsum += w;
      for (int i = 0; i < 4; i++) begin
         beat(8'h10 + 8'(i), (i == 3), 2, w);
         wsum += w;
      end
      chk("b2b_waits", wsum, 0);
      idle(3);

      // dropped frame with outputs stalled
      m_axis_tready = 4'h0;
      drop = 1'b1;
      select = 2'd0;
      wsum = 0;
      beat(8'h30, 1'b0, -1, w); wsum += w;
      drop = 1'b0;
      beat(8'h31, 1'b0, -1, w); wsum += w;
      beat(8'h32, 1'b1, -1, w); wsum += w;
      chk("drop_waits", wsum, 0);
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      chk("drop_tvalid", m_axis_tvalid, 4'b0);
      @(posedge clk);
      #1;
      m_axis_tready = 4'hF;
      beat(8'h40, 1'b0, 0, w);
      drop = 1'b1;
      beat(8'h41, 1'b0, 0, w);
      beat(8'h42, 1'b1, 0, w);
      drop = 1'b0;
      idle(2);

      // enable gating at frame start only
      enable = 1'b0;
      select = 2'd3;
      s_axis_tdata = 8'h50;
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("dis_tready", s_axis_tready, 1'b0);
         chk("dis_tvalid", m_axis_tvalid, 4'b0);
         @(posedge clk);
         #1;
      end
      enable = 1'b1;
      beat(8'h50, 1'b0, 3, w);
      enable = 1'b0;
      wsum = 0;
      beat(8'h51, 1'b0, 3, w); wsum += w;
      beat(8'h52, 1'b1, 3, w); wsum += w;
      chk("dis_mid_waits", wsum, 0);
      idle(1);
      enable = 1'b1;
      idle(2);

      // 16-beat frame to port 3 with toggling ready
      s_axis_tid = 8'h05;
      s_axis_tdest = 8'h07;
      select = 2'd3;
      m_axis_tready = 4'b0111;
      fork
         begin
            for (int i = 0; i < 16; i++) beat(8'(i), (i == 15), 3, w);
            s_axis_tvalid = 1'b0;
            t5done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!t5done) begin
               @(posedge clk);
               #1;
               m_axis_tready[3] = ~m_axis_tready[3];
               k++;
               if (k == 6) begin
                  @(negedge clk);
                  #2;
                  sr = s_axis_tready;
                  m_axis_tready = ~m_axis_tready;
                  #1;
                  chk("tready_no_comb", s_axis_tready, sr);
                  m_axis_tready = ~m_axis_tready;
               end
            end
         end
      join
      m_axis_tready = 4'hF;
      idle(6);

      // reset mid-frame
      s_axis_tid = 8'h01;
      s_axis_tdest = 8'h02;
      select = 2'd2;
      beat(8'h60, 1'b0, 2, w);
      beat(8'h61, 1'b0, 2, w);
      s_axis_tvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_tvalid", m_axis_tvalid, 4'b0);
      chk("rst_mid_tready", s_axis_tready, 1'b0);
      @(posedge clk);
      #1;
      select = 2'd0;
      beat(8'h70, 1'b0, 0, w);
      beat(8'h71, 1'b0, 0, w);
      beat(8'h72, 1'b1, 0, w);
      idle(1);

      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
      chk("sb_drained", sb.size(), 0);
      chk("end_tvalid", m_axis_tvalid, 4'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end

endmodule

// File: doc/axis_demux.md
Name: axis_demux

Overview:
- Frame-aware 1:M_COUNT AXI-Stream demultiplexer; the counterpart of axis_mux.
- Steers each complete frame from one input stream to one of M_COUNT output streams, chosen by a select input.
- Select is sampled at the start of each frame.
- Registered skid output stage gives full throughput with no combinational path from m_axis_tready to s_axis_tready.

Parameters:
- M_COUNT, 4, number of output streams (>=2).
- DATA_WIDTH, 8, tdata width.
- KEEP_ENABLE, (DATA_WIDTH>8), tkeep used; when 0, tkeep is driven all-ones.
- KEEP_WIDTH, (DATA_WIDTH/8), tkeep width.
- ID_ENABLE, 0, tid propagated; when 0, tid is driven 0.
- ID_WIDTH, 8, tid width.
- DEST_ENABLE, 0, tdest propagated; when 0, tdest is driven 0.
- DEST_WIDTH, 8, tdest width.
- USER_ENABLE, 1, tuser propagated; when 0, tuser is driven 0.
- USER_WIDTH, 1, tuser width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- s_axis_tdata  input  DATA_WIDTH  input data.
- s_axis_tkeep  input  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  input  1  input valid.
- s_axis_tready  output  1  input ready (registered).
- s_axis_tlast  input  1  end of frame.
- s_axis_tid  input  ID_WIDTH  stream ID.
- s_axis_tdest  input  DEST_WIDTH  routing tag.
- s_axis_tuser  input  USER_WIDTH  sideband.
- m_axis_tdata  output  M_COUNT*DATA_WIDTH  output data; the same value is replicated on every slice.
- m_axis_tkeep  output  M_COUNT*KEEP_WIDTH  replicated.
- m_axis_tvalid  output  M_COUNT  per-port valid; at most one bit set.
- m_axis_tready  input  M_COUNT  per-port ready.
- m_axis_tlast  output  M_COUNT  replicated.
- m_axis_tid  output  M_COUNT*ID_WIDTH  replicated.
- m_axis_tdest  output  M_COUNT*DEST_WIDTH  replicated.
- m_axis_tuser  output  M_COUNT*USER_WIDTH  replicated.
- enable  input  1  permit the start of a new frame.
- drop  input  1  discard the frame being started.
- select  input  $clog2(M_COUNT)  output port for the frame being started.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: m_axis_tvalid=0, s_axis_tready=0, frame_reg=0, drop_frame_reg=0, select_reg=0, temp (skid) valid=0.
- Frame start: a beat is a frame start when frame_reg=0.
  - s_axis_tready is gated by enable: no beat is accepted while enable=0.
  - On the accepted frame-start beat: latch select_reg=select and drop_frame_reg=drop, or drop_frame_reg=1 if select>=M_COUNT.
  - Set frame_reg=1 unless that beat also has tlast=1 (single-beat frame).
- Mid-frame: enable, select and drop are ignored.
  - The accepted beat with tlast=1 clears frame_reg.
  - The next beat is then a new frame start.
- Drop frames:
  - s_axis_tready=1 every cycle for the remainder of the frame, independent of m_axis_tready.
  - Beats are consumed and discarded; no m_axis_tvalid is produced.
  - Applies to the start beat too.
- Forwarded frames: an accepted beat appears on port select_reg one cycle later.
  - m_axis_tvalid[select_reg]=1; all other valid bits are 0.
  - Payload fields are held until m_axis_tready[select_reg]=1.
- Skid stage: output register plus temp register.
  - s_axis_tready next = m_axis_tready[sel] OR (temp empty AND (output empty OR input not valid)).
  - A beat accepted while the output is stalled goes to temp and moves to the output register when the output drains.
  - No beat is lost, duplicated or reordered.
  - Sustains 1 beat/cycle when the selected port's m_axis_tready=1.
- Port switching: a new frame on a different port may start while the previous frame's last beat is still buffered.
  - The buffered beat completes on the old port first; ordering across ports is preserved.
  - The output valid never switches port with a beat pending.
- Reset mid-frame: the partial frame is abandoned and output/temp valid are cleared.
  - The first beat accepted after reset is a frame start.
- Disabled fields (KEEP/ID/DEST/USER_ENABLE=0) drive constants as listed under Parameters; the input ports are ignored.

Test Plan:
- enable=1, select=1: 4-beat frame 0x01..0x04, tid=1, tdest=2, tlast on beat 4 -> beats on port 1 only, 1-cycle latency, m_axis_tvalid=4'b0010 throughout, data/tid/tdest match, port 1 tlast on 0x04.
- select changes 1->2 after beat 2 of a 4-beat frame -> whole frame on port 1; the next frame (0x10..0x13) goes to port 2 back-to-back with no bubble.
- drop=1 at frame start with m_axis_tready=0 -> s_axis_tready=1 every cycle, all 3 beats consumed, m_axis_tvalid stays 0. Following frame with drop=0 mid-frame is forwarded normally.
- enable=0 with s_axis_tvalid=1 -> s_axis_tready=0, no output. Raise enable -> frame accepted. Drop enable mid-frame -> frame still completes.
- continuous 16-beat frame to port 3 with m_axis_tready[3] toggling 1,0,1,0 -> output sequence 0x00..0x0F exact, no loss or duplicate; s_axis_tready never depends combinationally on m_axis_tready.
- rst pulsed for 1 cycle after beat 2 of 5 -> next cycle m_axis_tvalid=0 and s_axis_tready=0. Next frame with select=0 is routed to port 0 with select sampled fresh.
